// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for the bit-serial subtractor
//   in_valid/in_ready/in1/in2/bin   operand side (master drives operands, slave accepts)
//   out_valid/out_ready/diff/bout/ovf result side (slave presents, master consumes)
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, in1, in2, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, in1, in2, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial diff = in1 - in2 - bin with borrow-out and signed overflow
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_subtractor_if.slave: operands accepted in IDLE, result held in DONE until out_ready
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, diff_q;
    logic [CW-1:0]    cnt;
    logic             br, a_msb, b_msb, bout_q, ovf_q, in_ready_q, out_valid_q;
    logic             d, br_next;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ br;
        br_next = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
        r_next  = {d, r_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            r_sr        <= '0;
            cnt         <= '0;
            br          <= 1'b0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state      <= SHIFT;
                    a_sr       <= bus.in1;
                    b_sr       <= bus.in2;
                    br         <= bus.bin;
                    cnt        <= '0;
                    a_msb      <= bus.in1[WIDTH-1];
                    b_msb      <= bus.in2[WIDTH-1];
                    in_ready_q <= 1'b0;
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_next;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // the last processed bit is the result MSB, so d is the sign of diff
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        diff_q      <= r_next;
                        bout_q      <= br_next;
                        ovf_q       <= (a_msb != b_msb) & (d != a_msb);
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             b;
        logic             o;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    res_t sb[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
    serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_result: got %0h with no expected entry", bus.diff);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("result", {bus.diff, bus.bout, bus.ovf}, e);
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic eo, input int stall);
        int n;
        chk("idle_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in1 = a;
        bus.in2 = b;
        bus.bin = bi;
        sb.push_back({ed, eb, eo});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in1 = WIDTH'($urandom);
        bus.in2 = WIDTH'($urandom);
        bus.bin = 1'($urandom);
        n = 0;
        do begin
            if (!bus.out_valid) chk("busy_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 20);
        chk("latency", n, WIDTH);
        chk("done_in_ready", bus.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = i[0];
            bus.in1 = WIDTH'($urandom);
            bus.in2 = WIDTH'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_result", {bus.diff, bus.bout, bus.ovf}, {ed, eb, eo});
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_valid", bus.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.bin = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_result", {bus.diff, bus.bout, bus.ovf}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 0);
        run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, 1);
        run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 0);
        run_op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 2);
        run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 5);

        // Abort an operation two bit-edges in with an asynchronous reset pulse.
        bus.in_valid = 1'b1;
        bus.in1 = 4'b0101;
        bus.in2 = 4'b0011;
        bus.bin = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_in_ready", bus.in_ready, 1);
        chk("async_valid", bus.out_valid, 0);
        chk("async_result", {bus.diff, bus.bout, bus.ovf}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_valid", bus.out_valid, 0);
        end
        run_op(4'b1001, 4'b0100, 1'b0, 4'b0101, 1'b0, 1'b1, 0);

        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] a, b;
            logic             bi;
            logic [WIDTH:0]   f;
            logic             o;
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            bi = 1'($urandom);
            f  = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
            o  = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
            run_op(a, b, bi, f[WIDTH-1:0], f[WIDTH], o, int'($urandom_range(0, 3)));
        end

        @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
